// File: rtl/wb_pkg.sv
// Shared Wishbone burst-master definitions: cycle type identifiers and FSM states.
package wb_pkg;

  localparam logic [2:0] CTI_CLASSIC = 3'b000;
  localparam logic [2:0] CTI_INCR    = 3'b010;
  localparam logic [2:0] CTI_EOB     = 3'b111;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StBurst,
    StGap,
    StFin
  } wbm_state_t;

endpackage

// File: rtl/wbm_burst_calc.sv
// Beat count for the next burst: the smaller of the words still to move and the
// words left before the next MAX_BURST-word aligned boundary.
module wbm_burst_calc
  import wb_pkg::*;
#(
  parameter int unsigned APP_AW    = 26,
  parameter int unsigned dw        = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned BW        = $clog2(MAX_BURST) + 1
) (
  input  logic [APP_AW-1:0] i_addr,
  input  logic [LEN_W-1:0]  i_remaining,
  output logic [BW-1:0]     o_beats
);

  localparam int unsigned OFFW = $clog2(dw / 8);

  logic [APP_AW-1:0] w_word;
  logic [31:0]       w_off;
  logic [31:0]       w_room;
  logic [31:0]       w_rem;
  logic [31:0]       w_min;

  assign w_word = i_addr >> OFFW;

  // Words to the boundary, clipped by the remaining transfer length.
  always_comb begin
    w_off  = 32'(w_word) & 32'(MAX_BURST - 1);
    w_room = 32'(MAX_BURST) - w_off;
    w_rem  = 32'(i_remaining);
    w_min  = (w_rem < w_room) ? w_rem : w_room;
  end

  assign o_beats = BW'(w_min);

endmodule

// File: rtl/wb_burst_master.sv
// Wishbone burst master: splits a word-granular transfer command into
// incrementing bursts that never cross a MAX_BURST-word aligned boundary.
module wb_burst_master
  import wb_pkg::*;
#(
  parameter int unsigned APP_AW    = 26,
  parameter int unsigned dw        = 32,
  parameter int unsigned MAX_BURST = 8,
  parameter int unsigned LEN_W     = 16
) (
  input  logic              wb_clk_i,
  input  logic              reset_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [APP_AW-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic              cmd_we,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [dw-1:0]     wr_data,
  output logic              rd_valid,
  output logic [dw-1:0]     rd_data,
  output logic              busy,
  output logic              done,
  output logic              wb_cyc_o,
  output logic              wb_stb_o,
  output logic              wb_we_o,
  output logic [APP_AW-1:0] wb_addr_o,
  output logic [dw-1:0]     wb_dat_o,
  output logic [dw/8-1:0]   wb_sel_o,
  output logic [2:0]        wb_cti_o,
  input  logic              wb_ack_i,
  input  logic [dw-1:0]     wb_dat_i
);

  localparam int unsigned       BW         = $clog2(MAX_BURST) + 1;
  localparam int unsigned       BYTES      = dw / 8;
  localparam logic [APP_AW-1:0] STEP       = APP_AW'(BYTES);
  localparam logic [APP_AW-1:0] ALIGN_MASK = ~APP_AW'(BYTES - 1);

  wbm_state_t        r_state, w_state_d;
  logic [APP_AW-1:0] r_addr, w_addr_d;
  logic [LEN_W-1:0]  r_rem, w_rem_d;
  logic [BW-1:0]     r_beats, w_beats_d;
  logic              r_we, w_we_d;
  logic [2:0]        r_cti, w_cti_d;
  logic              r_cyc, w_cyc_d;
  logic              r_cmd_ready, w_cmd_ready_d;
  logic              r_busy, w_busy_d;
  logic              r_done, w_done_d;
  logic              r_rd_valid, w_rd_valid_d;
  logic [dw-1:0]     r_rd_data, w_rd_data_d;

  logic [BW-1:0]     w_calc_beats;
  logic              w_stb;
  logic              w_ack;

  wbm_burst_calc #(
    .APP_AW    (APP_AW),
    .dw        (dw),
    .MAX_BURST (MAX_BURST),
    .LEN_W     (LEN_W),
    .BW        (BW)
  ) u_burst_calc (
    .i_addr      (r_addr),
    .i_remaining (r_rem),
    .o_beats     (w_calc_beats)
  );

  // Strobe drops while a write beat has no data; acks outside a strobe are ignored.
  assign w_stb = (r_state == StBurst) && (!r_we || wr_valid);
  assign w_ack = w_stb && wb_ack_i;

  assign wr_ready  = w_ack && r_we;
  assign wb_dat_o  = ((r_state == StBurst) && r_we) ? wr_data : '0;
  assign wb_stb_o  = w_stb;
  assign wb_cyc_o  = r_cyc;
  assign wb_we_o   = r_we;
  assign wb_addr_o = r_addr;
  assign wb_cti_o  = r_cti;
  assign wb_sel_o  = '1;
  assign cmd_ready = r_cmd_ready;
  assign busy      = r_busy;
  assign done      = r_done;
  assign rd_valid  = r_rd_valid;
  assign rd_data   = r_rd_data;

  // State and registered outputs; reset abandons any transfer without a done pulse.
  always_ff @(posedge wb_clk_i or negedge reset_n) begin
    if (!reset_n) begin
      r_state     <= StIdle;
      r_addr      <= '0;
      r_rem       <= '0;
      r_beats     <= '0;
      r_we        <= 1'b0;
      r_cti       <= CTI_CLASSIC;
      r_cyc       <= 1'b0;
      r_cmd_ready <= 1'b1;
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_rd_valid  <= 1'b0;
      r_rd_data   <= '0;
    end else begin
      r_state     <= w_state_d;
      r_addr      <= w_addr_d;
      r_rem       <= w_rem_d;
      r_beats     <= w_beats_d;
      r_we        <= w_we_d;
      r_cti       <= w_cti_d;
      r_cyc       <= w_cyc_d;
      r_cmd_ready <= w_cmd_ready_d;
      r_busy      <= w_busy_d;
      r_done      <= w_done_d;
      r_rd_valid  <= w_rd_valid_d;
      r_rd_data   <= w_rd_data_d;
    end
  end

  // Next-state logic and next values of all registered outputs.
  always_comb begin
    w_state_d    = r_state;
    w_addr_d     = r_addr;
    w_rem_d      = r_rem;
    w_beats_d    = r_beats;
    w_we_d       = r_we;
    w_cti_d      = r_cti;
    w_busy_d     = r_busy;
    w_done_d     = 1'b0;
    w_rd_valid_d = 1'b0;
    w_rd_data_d  = r_rd_data;
    case (r_state)
      StIdle: begin
        if (cmd_valid && r_cmd_ready) begin
          w_addr_d  = cmd_addr & ALIGN_MASK;
          w_rem_d   = cmd_len;
          w_we_d    = cmd_we;
          w_busy_d  = 1'b1;
          w_state_d = (cmd_len == '0) ? StFin : StLoad;
        end
      end
      StLoad: begin
        w_beats_d = w_calc_beats;
        w_cti_d   = (w_calc_beats == BW'(1)) ? CTI_EOB : CTI_INCR;
        w_state_d = StBurst;
      end
      StBurst: begin
        if (w_ack) begin
          w_addr_d  = r_addr + STEP;
          w_rem_d   = r_rem - LEN_W'(1);
          w_beats_d = r_beats - BW'(1);
          if (!r_we) begin
            w_rd_valid_d = 1'b1;
            w_rd_data_d  = wb_dat_i;
          end
          if (r_beats == BW'(1)) begin
            w_cti_d   = CTI_CLASSIC;
            w_state_d = (w_rem_d != '0) ? StGap : StFin;
          end else if (r_beats == BW'(2)) begin
            w_cti_d = CTI_EOB;
          end else begin
            w_cti_d = CTI_INCR;
          end
        end
      end
      StGap: begin
        w_state_d = StLoad;
      end
      StFin: begin
        w_done_d  = 1'b1;
        w_busy_d  = 1'b0;
        w_state_d = StIdle;
      end
      default: begin
        w_state_d = StIdle;
      end
    endcase
    w_cmd_ready_d = (w_state_d == StIdle);
    // cyc stays up through LOAD so only the GAP cycle separates bursts.
    w_cyc_d       = (w_state_d == StLoad) || (w_state_d == StBurst);
  end

endmodule

// File: tb/tb_wb_burst_master.sv
// Randomised scoreboard bench for wb_burst_master with a behavioural burst model.
module tb_wb_burst_master;

  localparam int AW = 26;
  localparam int DW = 32;
  localparam int MB = 8;
  localparam int LW = 16;

  typedef struct {
    logic [AW-1:0] addr;
    logic [2:0]    cti;
    logic          we;
    logic [DW-1:0] data;
    bit            last;
  } beat_t;

  logic          clk, rst_n;
  logic          cmd_valid, cmd_ready, cmd_we;
  logic [AW-1:0] cmd_addr;
  logic [LW-1:0] cmd_len;
  logic          wr_valid, wr_ready;
  logic [DW-1:0] wr_data;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy, done;
  logic          wb_cyc_o, wb_stb_o, wb_we_o, wb_ack_i;
  logic [AW-1:0] wb_addr_o;
  logic [DW-1:0] wb_dat_o, wb_dat_i;
  logic [3:0]    wb_sel_o;
  logic [2:0]    wb_cti_o;

  beat_t         exp_q[$];
  logic [DW-1:0] exp_rd_q[$];
  int            exp_done_q[$];
  logic [DW-1:0] wr_q[$];

  int n_checks = 0, n_fail = 0;
  int cyc_n = 0, done_cnt = 0, cyc_hi_cnt = 0, wait_low_cnt = 0, lowrun = 0;
  int exp_busy_cyc = -1, exp_stb_cyc = -1;
  int min_wait = 0, max_wait = 0, wait_cnt = 0;
  bit spurious_en = 0;
  int stall_at = -1, stall_len = 0, stall_left = 0, stall_prob = 0, wr_sent = 0;
  bit stall_done = 0;
  bit w_hs;
  beat_t         mon_b;
  logic [DW-1:0] mon_rd;

  wb_burst_master #(
    .APP_AW    (AW),
    .dw        (DW),
    .MAX_BURST (MB),
    .LEN_W     (LW)
  ) dut (
    .wb_clk_i  (clk),
    .reset_n   (rst_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_we    (cmd_we),
    .wr_valid  (wr_valid),
    .wr_ready  (wr_ready),
    .wr_data   (wr_data),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data),
    .busy      (busy),
    .done      (done),
    .wb_cyc_o  (wb_cyc_o),
    .wb_stb_o  (wb_stb_o),
    .wb_we_o   (wb_we_o),
    .wb_addr_o (wb_addr_o),
    .wb_dat_o  (wb_dat_o),
    .wb_sel_o  (wb_sel_o),
    .wb_cti_o  (wb_cti_o),
    .wb_ack_i  (wb_ack_i),
    .wb_dat_i  (wb_dat_i)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc_n++;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc_n);
    $fatal(1, "watchdog");
  end

  // Slave read data is a fixed function of the word address.
  function automatic logic [DW-1:0] rdfun(input logic [AW-1:0] a);
    return {a, 6'h15} ^ 32'hC3A5_5A3C;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc_n);
    end
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: got event expected none (cycle %0d)", name, cyc_n);
  endtask

  // Reference: walk the transfer word by word, cutting bursts at MB-word boundaries.
  task automatic model(input logic [AW-1:0] a, input int len, input bit we);
    logic [AW-1:0] ad;
    int rem, room, b;
    beat_t bt;
    ad  = a & ~AW'(3);
    rem = len;
    while (rem > 0) begin
      room = MB - (int'(ad >> 2) % MB);
      b    = (rem < room) ? rem : room;
      for (int i = 0; i < b; i++) begin
        bt.addr = ad;
        bt.cti  = (i == b - 1) ? 3'b111 : 3'b010;
        bt.we   = we;
        bt.data = we ? DW'($urandom) : '0;
        bt.last = (rem == 1);
        if (we) wr_q.push_back(bt.data);
        else exp_rd_q.push_back(rdfun(ad));
        exp_q.push_back(bt);
        ad = ad + AW'(4);
        rem--;
      end
    end
  endtask

  // Wishbone slave: acks after a random number of wait cycles, sometimes acks with stb low.
  initial begin
    wb_ack_i = 1'b0;
    wb_dat_i = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        wb_ack_i = 1'b0;
        wait_cnt = 0;
      end else if (wb_cyc_o && wb_stb_o) begin
        if (wait_cnt == 0) begin
          wb_ack_i = 1'b1;
          wb_dat_i = rdfun(wb_addr_o);
          wait_cnt = $urandom_range(max_wait, min_wait);
        end else begin
          wb_ack_i = 1'b0;
          wait_cnt--;
        end
      end else begin
        wb_ack_i = wb_cyc_o && spurious_en && ($urandom_range(3, 0) == 0);
        wb_dat_i = DW'($urandom);
      end
    end
  end

  // Write-data source: presents wr_q in order with optional stalls.
  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(negedge clk);
      #3;
      w_hs = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (w_hs && wr_q.size() > 0) begin
        void'(wr_q.pop_front());
        wr_sent++;
      end
      if (stall_left > 0) begin
        stall_left--;
        wr_valid = 1'b0;
      end else if (!stall_done && stall_len > 0 && wr_sent == stall_at) begin
        stall_done = 1'b1;
        stall_left = stall_len - 1;
        wr_valid   = 1'b0;
      end else if (stall_prob > 0 && $urandom_range(99, 0) < stall_prob) begin
        wr_valid = 1'b0;
      end else begin
        wr_valid = (wr_q.size() > 0);
      end
      wr_data = (wr_q.size() > 0) ? wr_q[0] : '0;
    end
  end

  // Monitor: pops expectations whenever the DUT completes a beat, returns data or signals done.
  initial forever begin
    @(negedge clk);
    #3;
    if (rst_n) begin
      if (wb_cyc_o) cyc_hi_cnt++;
      if (wb_cyc_o && wb_we_o && !wb_stb_o && !wr_valid) wait_low_cnt++;
      if (cyc_n == exp_busy_cyc) chk("busy_after_accept", 64'(busy), 64'd1);
      if (cyc_n == exp_stb_cyc) chk("first_stb", 64'(wb_stb_o), 64'd1);
      if (wb_cyc_o && wb_we_o && !wr_valid) chk("stb_gated", 64'(wb_stb_o), 64'd0);
      if (wb_cyc_o && wb_stb_o && wb_ack_i) begin
        if (exp_q.size() == 0) fail_now("unexpected_beat");
        else begin
          mon_b = exp_q.pop_front();
          chk("beat_addr", 64'(wb_addr_o), 64'(mon_b.addr));
          chk("beat_cti", 64'(wb_cti_o), 64'(mon_b.cti));
          chk("beat_we", 64'(wb_we_o), 64'(mon_b.we));
          chk("beat_sel", 64'(wb_sel_o), 64'hF);
          if (mon_b.we) chk("wr_data", 64'(wb_dat_o), 64'(mon_b.data));
          if (mon_b.last) exp_done_q.push_back(cyc_n + 2);
        end
      end
      if (rd_valid) begin
        if (exp_rd_q.size() == 0) fail_now("unexpected_rd_valid");
        else begin
          mon_rd = exp_rd_q.pop_front();
          chk("rd_data", 64'(rd_data), 64'(mon_rd));
        end
      end
      if (done) begin
        done_cnt++;
        if (exp_done_q.size() == 0) fail_now("unexpected_done");
        else chk("done_cycle", 64'(cyc_n), 64'(exp_done_q.pop_front()));
      end
      if (!busy) lowrun = 0;
      else if (!wb_cyc_o) lowrun++;
      else begin
        if (lowrun > 0) chk("gap_len", 64'(lowrun), 64'd1);
        lowrun = 0;
      end
    end
  end

  task automatic issue(input logic [AW-1:0] a, input int len, input bit we);
    int k;
    @(posedge clk);
    #1;
    k = 0;
    while (!cmd_ready && k < 200) begin
      @(posedge clk);
      #1;
      k++;
    end
    if (!cmd_ready) begin
      chk("cmd_ready_timeout", 64'(cmd_ready), 64'd1);
      return;
    end
    model(a, len, we);
    cmd_addr     = a;
    cmd_len      = LW'(len);
    cmd_we       = we;
    cmd_valid    = 1'b1;
    exp_busy_cyc = cyc_n + 1;
    exp_stb_cyc  = (len > 0 && (!we || stall_prob == 0)) ? cyc_n + 2 : -1;
    if (len == 0) exp_done_q.push_back(cyc_n + 2);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic run_cmd(input logic [AW-1:0] a, input int len, input bit we);
    int target, k;
    target = done_cnt + 1;
    issue(a, len, we);
    k = 0;
    while (done_cnt < target && k < len * 12 + 100) begin
      @(posedge clk);
      k++;
    end
    chk("done_seen", 64'(done_cnt >= target), 64'd1);
    repeat (2) @(posedge clk);
    chk("beats_left", 64'(exp_q.size()), 64'd0);
    chk("rd_left", 64'(exp_rd_q.size()), 64'd0);
    chk("wr_left", 64'(wr_q.size()), 64'd0);
  endtask

  task automatic flush();
    exp_q.delete();
    exp_rd_q.delete();
    exp_done_q.delete();
    wr_q.delete();
    exp_busy_cyc = -1;
    exp_stb_cyc  = -1;
  endtask

  int base, d0;

  initial begin
    rst_n     = 1'b1;
    cmd_valid = 1'b0;
    cmd_addr  = '0;
    cmd_len   = '0;
    cmd_we    = 1'b0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_cmd_ready", 64'(cmd_ready), 64'd1);
    chk("rst_cyc", 64'(wb_cyc_o), 64'd0);
    chk("rst_stb", 64'(wb_stb_o), 64'd0);
    chk("rst_we", 64'(wb_we_o), 64'd0);
    chk("rst_busy_done_rdv", 64'({busy, done, rd_valid}), 64'd0);
    chk("rst_addr", 64'(wb_addr_o), 64'd0);
    chk("rst_dat_o", 64'(wb_dat_o), 64'd0);
    chk("rst_rd_data", 64'(rd_data), 64'd0);
    chk("rst_cti", 64'(wb_cti_o), 64'd0);
    chk("rst_sel", 64'(wb_sel_o), 64'hF);
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;

    run_cmd(26'h0, 8, 1'b0);
    run_cmd(26'h10, 20, 1'b1);

    base = wait_low_cnt;
    wr_sent = 0; stall_done = 0; stall_at = 3; stall_len = 3;
    run_cmd(26'h40, 12, 1'b1);
    chk("stall_stb_low_cycles", 64'(wait_low_cnt - base), 64'd3);
    stall_len = 0;

    min_wait = 2; max_wait = 2;
    run_cmd(26'h100, 10, 1'b0);
    min_wait = 0; max_wait = 0;

    base = cyc_hi_cnt;
    run_cmd(26'h200, 0, 1'b0);
    chk("len0_no_cyc", 64'(cyc_hi_cnt - base), 64'd0);
    run_cmd(26'h204, 1, 1'b1);
    run_cmd(26'h13, 5, 1'b0);
    run_cmd(26'h3FF_FFF0, 12, 1'b0);

    // Reset in the middle of a long read.
    issue(26'h400, 40, 1'b0);
    repeat (12) @(posedge clk);
    #3;
    chk("cyc_before_reset", 64'(wb_cyc_o), 64'd1);
    d0 = done_cnt;
    rst_n = 1'b0;
    #1;
    chk("reset_cyc", 64'(wb_cyc_o), 64'd0);
    chk("reset_stb", 64'(wb_stb_o), 64'd0);
    chk("reset_busy", 64'(busy), 64'd0);
    flush();
    repeat (3) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    chk("no_done_after_reset", 64'(done_cnt), 64'(d0));
    run_cmd(26'h800, 9, 1'b1);

    spurious_en = 1'b1;
    for (int n = 0; n < 25; n++) begin
      logic [AW-1:0] a;
      int len;
      bit we;
      a   = AW'($urandom);
      if ($urandom_range(3, 0) == 0) a = 26'h3FF_FFC0 | AW'($urandom_range(63, 0));
      len = $urandom_range(40, 0);
      if (n % 8 == 1) len = 1;
      we  = 1'($urandom_range(1, 0));
      max_wait   = $urandom_range(2, 0);
      stall_prob = we ? $urandom_range(30, 0) : 0;
      run_cmd(a, len, we);
    end
    stall_prob = 0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
